bitserial_mac_array: RTL and testbench

//  LANES-wide bit-serial multiply-accumulate engine for the bitserial_mac datapath.

---
 rtl/bitserial_mac_array.sv | 156 +++++++++++++++
 tb/tb_bitserial_mac_array.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_mac_array.sv
// LANES-wide bit-serial multiply-accumulate engine: parallel multiplicand, LSB-first serial multiplier,
// unsigned or two's-complement, optional accumulation, valid/ready result handshake.
module bitserial_mac_array #(
    parameter int unsigned MCAND_WIDTH  = 16,
    parameter int unsigned MPLIER_WIDTH = 16,
    parameter int unsigned LANES        = 4,
    parameter int unsigned ACC_WIDTH    = 40
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 in_ready,
    input  logic                                 signed_mode,
    input  logic                                 accumulate,
    input  logic [$clog2(MPLIER_WIDTH+1)-1:0]    nbits,
    input  logic [LANES*MCAND_WIDTH-1:0]         mcand,
    input  logic [LANES-1:0]                     serial_bit,
    output logic                                 bit_req,
    input  logic                                 abort,
    output logic [LANES*ACC_WIDTH-1:0]           acc_out,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int unsigned NB_W    = $clog2(MPLIER_WIDTH + 1);
    localparam int unsigned EXT_W   = ACC_WIDTH - MCAND_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [NB_W-1:0]                     count_q, count_d;
    logic [NB_W-1:0]                     n_q, n_d;
    logic                                signed_q, signed_d;
    logic [LANES-1:0][MCAND_WIDTH-1:0]   mcand_q, mcand_d;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc_q, acc_d;
    logic                                in_ready_q, in_ready_d;
    logic                                bit_req_q, bit_req_d;
    logic                                out_valid_q, out_valid_d;

    logic [NB_W-1:0]                     n_eff_c;
    logic                                last_bit_c;
    logic [LANES-1:0][ACC_WIDTH-1:0]     term_c;

    // Out-of-range serial length (0 or too long) falls back to the full multiplier width
    assign n_eff_c    = ((nbits == '0) || (nbits > NB_W'(MPLIER_WIDTH))) ? NB_W'(MPLIER_WIDTH) : nbits;
    assign last_bit_c = (count_q == (n_q - NB_W'(1)));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ACC_WIDTH-1:0] ext;
        assign ext       = {{EXT_W{signed_q & mcand_q[l][MCAND_WIDTH-1]}}, mcand_q[l]};
        assign term_c[l] = ext << count_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        n_d         = n_q;
        signed_d    = signed_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        bit_req_d   = bit_req_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d    = mcand;
                    signed_d   = signed_mode;
                    n_d        = n_eff_c;
                    count_d    = '0;
                    if (!accumulate) begin
                        acc_d = '0;
                    end
                    state_d    = ST_CALC;
                    in_ready_d = 1'b0;
                    bit_req_d  = 1'b1;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    acc_d      = '0;
                    count_d    = '0;
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    bit_req_d  = 1'b0;
                end else begin
                    // In signed mode the final bit carries weight -2^(N-1)
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (serial_bit[l]) begin
                            acc_d[l] = (signed_q && last_bit_c) ? (acc_q[l] - term_c[l])
                                                                : (acc_q[l] + term_c[l]);
                        end
                    end
                    count_d = count_q + NB_W'(1);
                    if (last_bit_c) begin
                        state_d     = ST_DONE;
                        bit_req_d   = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    if (abort) begin
                        acc_d = '0;
                    end
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                bit_req_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            n_q         <= '0;
            signed_q    <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            bit_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            n_q         <= n_d;
            signed_q    <= signed_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            bit_req_q   <= bit_req_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bit_req   = bit_req_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Directed, table-driven bench for bitserial_mac_array with hand-computed products and
// hand-written sequences for stall, abort and mid-op reset.
module tb_bitserial_mac_array;

    localparam int unsigned MW  = 16;
    localparam int unsigned PW  = 16;
    localparam int unsigned L   = 4;
    localparam int unsigned AW  = 40;
    localparam int unsigned NBW = $clog2(PW + 1);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               in_ready;
    logic               signed_mode;
    logic               accumulate;
    logic [NBW-1:0]     nbits;
    logic [L*MW-1:0]    mcand;
    logic [L-1:0]       serial_bit;
    logic               bit_req;
    logic               abort;
    logic [L*AW-1:0]    acc_out;
    logic               out_valid;
    logic               out_ready;

    bitserial_mac_array #(
        .MCAND_WIDTH (MW),
        .MPLIER_WIDTH(PW),
        .LANES       (L),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_ready   (in_ready),
        .signed_mode(signed_mode),
        .accumulate (accumulate),
        .nbits      (nbits),
        .mcand      (mcand),
        .serial_bit (serial_bit),
        .bit_req    (bit_req),
        .abort      (abort),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0][MW-1:0] mc;
        logic [L-1:0][PW-1:0] ml;
        logic [NBW-1:0]       nb;
        logic                 sg;
        logic                 ac;
        int                   n_eff;
        logic [L-1:0][AW-1:0] exp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_acc(input string name, input logic [L-1:0][AW-1:0] exp);
        for (int l = 0; l < L; l++) begin
            check($sformatf("%s acc lane%0d", name, l), 64'(acc_out[l*AW +: AW]), 64'(exp[l]));
        end
    endtask

    task automatic start_op(input logic [L-1:0][MW-1:0] mc, input logic [NBW-1:0] nb,
                            input logic sg, input logic ac, input logic ab);
        @(negedge clk);
        mcand       = mc;
        nbits       = nb;
        signed_mode = sg;
        accumulate  = ac;
        abort       = ab;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        abort       = 1'b0;
    endtask

    // Streams multiplier bits while bit_req is high; lat counts cycles from accept to out_valid
    task automatic feed_bits(input logic [L-1:0][PW-1:0] ml, input int abort_at, output int lat);
        int  k;
        bit  aborted;
        k       = 0;
        lat     = 0;
        aborted = 1'b0;
        while (!out_valid && !aborted && lat < 64) begin
            if (bit_req) begin
                for (int l = 0; l < L; l++) serial_bit[l] = ml[l][k];
                abort   = (k == abort_at);
                aborted = (k == abort_at);
                k++;
            end
            @(negedge clk);
            abort = 1'b0;
            lat++;
        end
        if (lat >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_bits timeout: out_valid not seen after %0d cycles", lat);
        end
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [L-1:0][AW-1:0] held;

        // lanes listed lane3 .. lane0
        vecs[0]  = '{mc: {16'hFFFF, 16'd0, 16'd100, 16'd3}, ml: {16'd5, 16'd9, 16'd2, 16'd5},
                     nb: 5'd16, sg: 1'b0, ac: 1'b0, n_eff: 16,
                     exp: {40'd327675, 40'd0, 40'd200, 40'd15}};
        vecs[1]  = '{mc: {16'hFFFF, 16'd1, 16'd7, 16'hFFFD}, ml: {16'h00FF, 16'h007F, 16'h0080, 16'h00FB},
                     nb: 5'd8, sg: 1'b1, ac: 1'b0, n_eff: 8,
                     exp: {40'd1, 40'd127, 40'(-896), 40'd15}};
        vecs[2]  = '{mc: {16'd0, 16'd5, 16'hFFFF, 16'd10}, ml: {16'd7, 16'd0, 16'hFFFF, 16'd10},
                     nb: 5'd16, sg: 1'b0, ac: 1'b0, n_eff: 16,
                     exp: {40'd0, 40'd0, 40'd4294836225, 40'd100}};
        vecs[3]  = '{mc: {16'd0, 16'd5, 16'd1, 16'd2}, ml: {16'd7, 16'd1, 16'd1, 16'd3},
                     nb: 5'd16, sg: 1'b0, ac: 1'b1, n_eff: 16,
                     exp: {40'd0, 40'd5, 40'd4294836226, 40'd106}};
        vecs[4]  = '{mc: {16'd4, 16'd3, 16'd2, 16'd1}, ml: {16'd0, 16'd1, 16'd1, 16'd1},
                     nb: 5'd16, sg: 1'b0, ac: 1'b0, n_eff: 16,
                     exp: {40'd0, 40'd3, 40'd2, 40'd1}};
        vecs[5]  = '{mc: {16'd4, 16'd3, 16'd2, 16'd1}, ml: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                     nb: 5'd16, sg: 1'b0, ac: 1'b0, n_eff: 16,
                     exp: {40'd262140, 40'd196605, 40'd131070, 40'd65535}};
        vecs[6]  = '{mc: {16'd0, 16'd9, 16'hFFFE, 16'd5}, ml: {16'd1, 16'd0, 16'd1, 16'd1},
                     nb: 5'd1, sg: 1'b1, ac: 1'b0, n_eff: 1,
                     exp: {40'd0, 40'd0, 40'd2, 40'(-5)}};
        vecs[7]  = '{mc: {16'd0, 16'd1, 16'hFFFF, 16'd3}, ml: {16'hFFFF, 16'hFFFF, 16'd2, 16'h8000},
                     nb: 5'd0, sg: 1'b0, ac: 1'b0, n_eff: 16,
                     exp: {40'd0, 40'd65535, 40'd131070, 40'd98304}};
        vecs[8]  = '{mc: {16'h8000, 16'h7FFF, 16'd2, 16'hFFFF}, ml: {16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000},
                     nb: 5'd31, sg: 1'b1, ac: 1'b0, n_eff: 16,
                     exp: {40'd1073741824, 40'd1073676289, 40'(-2), 40'd32768}};
        vecs[9]  = '{mc: {16'h7FFF, 16'h8000, 16'hFFFB, 16'd3}, ml: {16'h1, 16'h8, 16'h7, 16'hA},
                     nb: 5'd4, sg: 1'b1, ac: 1'b0, n_eff: 4,
                     exp: {40'd32767, 40'd262144, 40'(-35), 40'(-18)}};
        vecs[10] = '{mc: {16'd1, 16'd0, 16'd8, 16'hFFFF}, ml: {16'h0FE1, 16'h1F, 16'h10, 16'h1F},
                     nb: 5'd5, sg: 1'b0, ac: 1'b0, n_eff: 5,
                     exp: {40'd1, 40'd0, 40'd128, 40'd2031585}};
        vecs[11] = '{mc: {16'd0, 16'd0, 16'd0, 16'hFFFF}, ml: {16'd0, 16'd0, 16'd0, 16'd1},
                     nb: 5'd16, sg: 1'b1, ac: 1'b1, n_eff: 16,
                     exp: {40'd1, 40'd0, 40'd128, 40'd2031584}};

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        accumulate  = 1'b0;
        nbits       = '0;
        mcand       = '0;
        serial_bit  = '0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset bit_req", 64'(bit_req), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset acc_out", 64'(acc_out == '0), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].mc, vecs[i].nb, vecs[i].sg, vecs[i].ac, 1'b0);
            feed_bits(vecs[i].ml, -1, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].n_eff));
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check_acc($sformatf("vec%0d", i), vecs[i].exp);
            finish_op($sformatf("vec%0d", i));
        end

        // Stall: out_valid/acc_out hold while out_ready is low, start ignored
        start_op({16'd0, 16'd0, 16'd0, 16'd9}, 5'd4, 1'b0, 1'b0, 1'b0);
        feed_bits({16'd0, 16'd0, 16'd0, 16'd9}, -1, lat);
        check("stall latency", 64'(lat), 64'd4);
        held = {40'd0, 40'd0, 40'd0, 40'd81};
        for (int c = 0; c < 5; c++) begin
            mcand = {16'd7, 16'd7, 16'd7, 16'd7};
            start = 1'b1;
            check($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'd0);
            check_acc($sformatf("stall%0d", c), held);
            @(negedge clk);
        end
        start = 1'b0;
        finish_op("stall");
        check_acc("stall after handshake", held);

        // Abort mid-calc at bit 3 clears accumulators and never raises out_valid
        start_op({16'd5, 16'd5, 16'd5, 16'd5}, 5'd8, 1'b0, 1'b1, 1'b0);
        feed_bits({16'hFF, 16'hFF, 16'hFF, 16'hFF}, 3, lat);
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort bit_req", 64'(bit_req), 64'd0);
        check("abort acc cleared", 64'(acc_out == '0), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort idle%0d out_valid", c), 64'(out_valid), 64'd0);
        end
        start_op({16'd0, 16'd0, 16'd0, 16'd3}, 5'd8, 1'b0, 1'b1, 1'b0);
        feed_bits({16'd0, 16'd0, 16'd0, 16'd4}, -1, lat);
        check("post-abort latency", 64'(lat), 64'd8);
        check_acc("post-abort", {40'd0, 40'd0, 40'd0, 40'd12});
        finish_op("post-abort");

        // Abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort in_ready", 64'(in_ready), 64'd1);
        check_acc("idle abort", {40'd0, 40'd0, 40'd0, 40'd12});

        // Start and abort together in IDLE: start wins
        start_op({16'd0, 16'd0, 16'd0, 16'd6}, 5'd3, 1'b0, 1'b0, 1'b1);
        feed_bits({16'd0, 16'd0, 16'd0, 16'd7}, -1, lat);
        check("start+abort latency", 64'(lat), 64'd3);
        check_acc("start+abort", {40'd0, 40'd0, 40'd0, 40'd42});

        // Abort in DONE drops the result
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("done abort out_valid", 64'(out_valid), 64'd0);
        check("done abort in_ready", 64'(in_ready), 64'd1);
        check("done abort acc cleared", 64'(acc_out == '0), 64'd1);

        // Asynchronous reset while bit 7 is pending
        start_op({16'd1, 16'd1, 16'd1, 16'd1}, 5'd16, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            serial_bit = '1;
            @(negedge clk);
        end
        check("pre-reset bit_req", 64'(bit_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid-op reset in_ready", 64'(in_ready), 64'd1);
        check("mid-op reset bit_req", 64'(bit_req), 64'd0);
        check("mid-op reset out_valid", 64'(out_valid), 64'd0);
        check("mid-op reset acc_out", 64'(acc_out == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_op({16'd0, 16'd0, 16'd2, 16'd11}, 5'd8, 1'b0, 1'b1, 1'b0);
        feed_bits({16'd0, 16'd0, 16'd3, 16'd11}, -1, lat);
        check("post-reset latency", 64'(lat), 64'd8);
        check_acc("post-reset", {40'd0, 40'd0, 40'd6, 40'd121});
        finish_op("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
